// File: rtl/wb_data_ram.sv
// Wishbone data RAM, 2**ADDR_W x 32-bit words with byte lanes; ack/err is registered WAIT_CYCLES+1 edges after the
// request edge. Requests are accepted only in IDLE, inputs are ignored until then, and dropping cyc during WAIT aborts.
module wb_data_ram #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       adr_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_q;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word;

  logic              take;
  logic              enter_resp;
  logic [31:0]       cur_adr;
  logic              cur_we;
  logic [3:0]        cur_sel;
  logic [31:0]       cur_dat;
  logic [ADDR_W-1:0] cur_idx;
  logic              cur_bad;
  logic              resp_bad;
  logic              ack_d, err_d;
  logic [31:0]       dat_d;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
  endfunction

  // With zero wait states RESP is entered on the sampling edge itself, so the
  // memory port must see the live bus rather than the not-yet-latched copy.
  assign take       = (state_q == IDLE) && wb_cyc_i && wb_stb_i;
  assign cur_adr    = take ? wb_adr_i : adr_q;
  assign cur_we     = take ? wb_we_i  : we_q;
  assign cur_sel    = take ? wb_sel_i : sel_q;
  assign cur_dat    = take ? wb_dat_i : dat_q;
  assign cur_idx    = cur_adr[ADDR_W+1:2];
  assign cur_bad    = addr_bad(cur_adr);
  assign resp_bad   = addr_bad(adr_q);
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d = 1'b0;
    err_d = 1'b0;
    dat_d = 32'd0;
    if (state_q == RESP) begin
      ack_d = !resp_bad;
      err_d = resp_bad;
      if (!resp_bad && !we_q) dat_d = rd_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      adr_q    <= 32'd0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      dat_q    <= 32'd0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        adr_q <= wb_adr_i;
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i;
        dat_q <= wb_dat_i;
      end
      wb_ack_o <= ack_d;
      wb_err_o <= err_d;
      wb_dat_o <= dat_d;
    end
  end

  // Memory is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (enter_resp && !rst) begin
      rd_word <= mem[cur_idx];
      if (cur_we && !cur_bad) begin
        if (cur_sel[0]) mem[cur_idx][7:0]   <= cur_dat[7:0];
        if (cur_sel[1]) mem[cur_idx][15:8]  <= cur_dat[15:8];
        if (cur_sel[2]) mem[cur_idx][23:16] <= cur_dat[23:16];
        if (cur_sel[3]) mem[cur_idx][31:24] <= cur_dat[31:24];
      end
    end
  end

endmodule

// File: doc/wb_data_ram.md
WB_DATA_RAM -- requirements
Module: wb_data_ram

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; memory holds 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before acknowledge; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wb_cyc_i  input  1  bus cycle in progress.
REQ-006 wb_stb_i  input  1  transfer strobe.
REQ-007 wb_we_i  input  1  1 = write, 0 = read.
REQ-008 wb_adr_i  input  32  byte address.
REQ-009 wb_sel_i  input  4  byte-lane enables; sel[i] covers data bits 8i+7:8i.
REQ-010 wb_dat_i  input  32  write data.
REQ-011 wb_dat_o  output  32  read data.
REQ-012 wb_ack_o  output  1  normal transfer termination.
REQ-013 wb_err_o  output  1  error transfer termination.

Function
REQ-014 FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-015 IDLE with wb_cyc_i & wb_stb_i high at an edge: latch adr, we, sel, dat_i; go to WAIT with counter = WAIT_CYCLES-1, or straight to RESP when WAIT_CYCLES = 0.
REQ-016 WAIT: counter decrements each edge; at counter = 0 go to RESP.
REQ-017 RESP lasts exactly one cycle and returns to IDLE; termination is ack or err, never both.
REQ-018 Latency: termination high in the cycle beginning WAIT_CYCLES+1 edges after the request-sampling edge.
REQ-019 Error condition: latched adr[1:0] != 0 or adr[31:ADDR_W+2] != 0; raises wb_err_o instead of wb_ack_o, no memory write, wb_dat_o = 0.
REQ-020 Write (no error): on the edge entering RESP, each lane with sel[i] = 1 is updated from latched data; other lanes are unchanged; sel = 0000 still acks with no change.
REQ-021 Read (no error): wb_dat_o = full word at index adr[ADDR_W+1:2] during the ack cycle, regardless of sel; 0 in every non-termination cycle.
REQ-022 Input changes after the request-sampling edge are ignored until IDLE.
REQ-023 Abort: wb_cyc_i low at any edge while in WAIT returns to IDLE; no write, no ack/err.
REQ-024 wb_cyc_i & wb_stb_i held high through termination starts a new transfer at the first IDLE edge; one idle cycle minimum between terminations.
REQ-025 Reads observe all writes terminated earlier; write-then-read of the same word returns the new data.

Reset
REQ-026 rst high forces IDLE, counter 0, wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0 immediately, independent of clk.
REQ-027 rst mid-transfer discards the transfer: no write, no termination.
REQ-028 Memory contents are not cleared by reset.

Verification
REQ-029 WAIT_CYCLES=2: write adr 0x10, sel 1111, dat 0xDEADBEEF, then read 0x10 -> each ack 3 cycles after request, read data 0xDEADBEEF.
REQ-030 Word at 0x20 = 0x11223344; write sel 0101, dat 0xAABBCCDD, then read -> 0x11BB33DD.
REQ-031 Read adr 0x22, then read adr 0x00001000 (ADDR_W=10) -> wb_err_o one cycle each, wb_ack_o 0, wb_dat_o 0, memory unchanged.
REQ-032 Write 0x55 to 0x30, drop wb_cyc_i one cycle after request -> no ack; subsequent read 0x30 returns prior value.
REQ-033 Assert rst during WAIT of a write -> outputs 0 at once, no ack after release, word unchanged; previously written words retained.
REQ-034 WAIT_CYCLES=0, cyc/stb held high for four reads -> ack every other cycle, one cycle after each sampling edge.
